// File: rtl/rst_pkg.sv
// Shared types and helpers for the register status table and its checkpoints.
package rst_pkg;

    localparam int TAG_W    = 6;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = $clog2(NUM_REGS);

    // One status entry: busy flag plus the tag of the in-flight producer.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } rst_entry_t;

    // True when a single CDB port retires the producer named by this entry.
    function automatic logic cdb_match(rst_entry_t entry, logic [TAG_W-1:0] cdb_tag,
                                       logic cdb_valid);
        return cdb_valid && entry.valid && (entry.tag == cdb_tag);
    endfunction

endpackage

// File: rtl/rst_ckpt_if.sv
// Dispatch / CDB / checkpoint bundle between the dispatch stage and the status table.
interface rst_ckpt_if #(
    parameter int NUM_CDB  = 2,
    parameter int NUM_CKPT = 4
);
    import rst_pkg::*;

    localparam int CKPT_AW = $clog2(NUM_CKPT);

    logic [TAG_W-1:0]            dispatch_tag;
    logic [REG_AW-1:0]           dispatch_addr;
    logic                        dispatch_wen;
    logic [REG_AW-1:0]           dispatch_rsaddr;
    logic [TAG_W-1:0]            dispatch_rstag;
    logic                        dispatch_rsvalid;
    logic [REG_AW-1:0]           dispatch_rtaddr;
    logic [TAG_W-1:0]            dispatch_rttag;
    logic                        dispatch_rtvalid;
    logic [NUM_CDB*TAG_W-1:0]    cdb_tag;
    logic [NUM_CDB-1:0]          cdb_valid;
    logic [NUM_CDB*NUM_REGS-1:0] regfile_wen_onehot;
    logic                        ckpt_save;
    logic                        ckpt_flush;
    logic [CKPT_AW-1:0]          ckpt_id;
    logic [NUM_CKPT-1:0]         ckpt_valid;
    logic [NUM_CKPT-1:0]         ckpt_release;

    modport master (
        output dispatch_tag, dispatch_addr, dispatch_wen, dispatch_rsaddr, dispatch_rtaddr,
               cdb_tag, cdb_valid, ckpt_save, ckpt_flush, ckpt_id, ckpt_release,
        input  dispatch_rstag, dispatch_rsvalid, dispatch_rttag, dispatch_rtvalid,
               regfile_wen_onehot, ckpt_valid
    );

    modport slave (
        input  dispatch_tag, dispatch_addr, dispatch_wen, dispatch_rsaddr, dispatch_rtaddr,
               cdb_tag, cdb_valid, ckpt_save, ckpt_flush, ckpt_id, ckpt_release,
        output dispatch_rstag, dispatch_rsvalid, dispatch_rttag, dispatch_rtvalid,
               regfile_wen_onehot, ckpt_valid
    );

endinterface

// File: rtl/rst_ckpt_slot.sv
// One checkpoint copy of the status table. Keeps retiring producers from the
// CDB so a later restore never brings back a completed result as busy.
module rst_ckpt_slot
    import rst_pkg::*;
#(
    parameter int NUM_CDB = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CDB-1:0][TAG_W-1:0]     cdb_tag,
    input  logic [NUM_CDB-1:0]                cdb_valid,
    input  logic                              save,
    input  rst_entry_t [NUM_REGS-1:0]         save_data,
    output rst_entry_t [NUM_REGS-1:0]         data_clr
);

    rst_entry_t [NUM_REGS-1:0] data_q;

    // Stored copy with this cycle's CDB completions removed; also the restore view.
    always_comb begin
        data_clr    = data_q;
        data_clr[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int p = 0; p < NUM_CDB; p++) begin
                if (cdb_match(data_q[r], cdb_tag[p], cdb_valid[p])) data_clr[r] = '0;
            end
        end
    end

    // A save replaces the whole copy; otherwise it just tracks CDB clears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) data_q <= '0;
        else        data_q <= save ? save_data : data_clr;
    end

endmodule

// File: rtl/rst_ckpt.sv
// Register status table for Tomasulo dispatch: live {valid, tag} table with
// CDB bypass on the read ports, per-CDB register-file write enables, and
// NUM_CKPT branch checkpoints that can be restored on a mispredict.
module rst_ckpt
    import rst_pkg::*;
#(
    parameter int NUM_CDB  = 2,
    parameter int NUM_CKPT = 4
) (
    input logic       clk,
    input logic       reset,
    rst_ckpt_if.slave bus
);

    localparam int CKPT_AW = $clog2(NUM_CKPT);

    rst_entry_t [NUM_REGS-1:0]                table_q;
    rst_entry_t [NUM_REGS-1:0]                table_clr;
    rst_entry_t [NUM_REGS-1:0]                table_nxt;
    rst_entry_t [NUM_CKPT-1:0][NUM_REGS-1:0]  slot_clr;
    logic       [NUM_CDB-1:0][TAG_W-1:0]      cdb_tag_a;
    logic       [NUM_CDB-1:0][NUM_REGS-1:0]   cdb_hit;
    logic       [NUM_REGS-1:0]                any_hit;
    logic       [NUM_CKPT-1:0]                ckpt_valid_q;
    logic       [NUM_CKPT-1:0]                ckpt_valid_nxt;
    logic                                     disp_hit;
    logic                                     flush_ok;
    logic                                     save_ok;
    rst_entry_t                               wr_entry;
    rst_entry_t                               rs_entry;
    rst_entry_t                               rt_entry;

    assign cdb_tag_a = bus.cdb_tag;

    // Per-port, per-register match; r0 is never busy so it never matches.
    for (genvar p = 0; p < NUM_CDB; p++) begin : g_port
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
            if (r == 0) begin : g_zero
                assign cdb_hit[p][r] = 1'b0;
            end else begin : g_match
                assign cdb_hit[p][r] = cdb_match(table_q[r], cdb_tag_a[p], bus.cdb_valid[p]);
            end
        end
    end

    assign bus.regfile_wen_onehot = cdb_hit;

    // Collapse the CDB ports: which entries retire now, and does the dispatching tag itself retire.
    always_comb begin
        any_hit  = '0;
        disp_hit = 1'b0;
        for (int p = 0; p < NUM_CDB; p++) begin
            any_hit  = any_hit | cdb_hit[p];
            disp_hit = disp_hit | (bus.cdb_valid[p] && (cdb_tag_a[p] == bus.dispatch_tag));
        end
    end

    assign flush_ok = bus.ckpt_flush && ckpt_valid_q[bus.ckpt_id];
    assign save_ok  = bus.ckpt_save && !flush_ok;

    // A producer that completes in its own dispatch cycle leaves the register ready.
    always_comb begin
        wr_entry.valid = !disp_hit;
        wr_entry.tag   = disp_hit ? '0 : bus.dispatch_tag;
    end

    // Next live table: CDB clears, then either a restore or the dispatch write on top.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) table_clr[r] = any_hit[r] ? '0 : table_q[r];
        table_clr[0] = '0;
        table_nxt    = table_clr;
        if (flush_ok) begin
            table_nxt = slot_clr[bus.ckpt_id];
        end else if (bus.dispatch_wen && (bus.dispatch_addr != '0)) begin
            table_nxt[bus.dispatch_addr] = wr_entry;
        end
    end

    // Live table register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) table_q <= '0;
        else        table_q <= table_nxt;
    end

    // Read ports: stored tag always shown, busy masked by a same-cycle CDB hit.
    always_comb begin
        rs_entry             = table_q[bus.dispatch_rsaddr];
        rt_entry             = table_q[bus.dispatch_rtaddr];
        bus.dispatch_rsvalid = (bus.dispatch_rsaddr != '0) && rs_entry.valid &&
                               !any_hit[bus.dispatch_rsaddr];
        bus.dispatch_rstag   = (bus.dispatch_rsaddr != '0) ? rs_entry.tag : '0;
        bus.dispatch_rtvalid = (bus.dispatch_rtaddr != '0) && rt_entry.valid &&
                               !any_hit[bus.dispatch_rtaddr];
        bus.dispatch_rttag   = (bus.dispatch_rtaddr != '0) ? rt_entry.tag : '0;
    end

    // Slot occupancy: a restore squashes every branch; a save beats a same-cycle release.
    always_comb begin
        ckpt_valid_nxt = ckpt_valid_q & ~bus.ckpt_release;
        if (flush_ok)     ckpt_valid_nxt = '0;
        else if (save_ok) ckpt_valid_nxt[bus.ckpt_id] = 1'b1;
    end

    // Slot occupancy register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ckpt_valid_q <= '0;
        else        ckpt_valid_q <= ckpt_valid_nxt;
    end

    assign bus.ckpt_valid = ckpt_valid_q;

    // Snapshots take the next-state table so same-cycle dispatch and clears are included.
    for (genvar k = 0; k < NUM_CKPT; k++) begin : g_slot
        rst_ckpt_slot #(.NUM_CDB(NUM_CDB)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .cdb_tag   (cdb_tag_a),
            .cdb_valid (bus.cdb_valid),
            .save      (save_ok && (bus.ckpt_id == CKPT_AW'(k))),
            .save_data (table_nxt),
            .data_clr  (slot_clr[k])
        );
    end

`ifndef SYNTHESIS
    // Restoring an empty slot means the branch unit lost track of its checkpoints.
    always_ff @(posedge clk) begin
        if (reset && bus.ckpt_flush) assert (ckpt_valid_q[bus.ckpt_id]);
    end
`endif

endmodule

// File: tb/tb_rst_ckpt.sv
// Randomized scoreboard bench for rst_ckpt: the driver predicts each cycle's
// read-port/onehot/ckpt_valid response from a register-ownership model and
// queues it; a negedge monitor pops and compares against the DUT.
module tb_rst_ckpt;
    import rst_pkg::*;

    localparam int NCDB    = 2;
    localparam int NCKPT   = 4;
    localparam int CKPT_AW = $clog2(NCKPT);
    localparam int OH_W    = NCDB * NUM_REGS;
    localparam int NTAGS   = 1 << TAG_W;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rst_ckpt_if #(.NUM_CDB(NCDB), .NUM_CKPT(NCKPT)) bus ();
    rst_ckpt #(.NUM_CDB(NCDB), .NUM_CKPT(NCKPT)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        bit             wen;
        int             waddr;
        int             wtag;
        int             rs;
        int             rt;
        bit             cdb_v[NCDB];
        int             cdb_t[NCDB];
        bit             save;
        bit             flush;
        int             id;
        bit [NCKPT-1:0] rel;
    } stim_t;

    typedef struct {
        logic             rsv;
        logic [TAG_W-1:0] rst;
        logic             rtv;
        logic [TAG_W-1:0] rtt;
        logic [OH_W-1:0]  oh;
        logic [NCKPT-1:0] ckv;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   tag_ptr = 0;

    // Model: owner tag per register (-1 = ready), per checkpoint copy, slot occupancy.
    int own[NUM_REGS];
    int snap[NCKPT][NUM_REGS];
    bit ckv[NCKPT];

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) begin
            own[r] = -1;
            for (int k = 0; k < NCKPT; k++) snap[k][r] = -1;
        end
        for (int k = 0; k < NCKPT; k++) ckv[k] = 1'b0;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.wen = 0; s.waddr = 0; s.wtag = 0; s.rs = 0; s.rt = 0;
        for (int p = 0; p < NCDB; p++) begin s.cdb_v[p] = 0; s.cdb_t[p] = 0; end
        s.save = 0; s.flush = 0; s.id = 0; s.rel = '0;
        return s;
    endfunction

    function automatic bit completes(stim_t s, int t);
        for (int p = 0; p < NCDB; p++) if (s.cdb_v[p] && s.cdb_t[p] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_flight(int t);
        for (int r = 0; r < NUM_REGS; r++) begin
            if (own[r] == t) return 1'b1;
            for (int k = 0; k < NCKPT; k++) if (ckv[k] && snap[k][r] == t) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int free_tag();
        for (int i = 0; i < NTAGS; i++) begin
            int t;
            t = (tag_ptr + i) % NTAGS;
            if (!in_flight(t)) begin
                tag_ptr = (t + 1) % NTAGS;
                return t;
            end
        end
        return -1;
    endfunction

    task automatic drive(stim_t s);
        bus.dispatch_wen    = s.wen;
        bus.dispatch_addr   = REG_AW'(s.waddr);
        bus.dispatch_tag    = TAG_W'(s.wtag);
        bus.dispatch_rsaddr = REG_AW'(s.rs);
        bus.dispatch_rtaddr = REG_AW'(s.rt);
        for (int p = 0; p < NCDB; p++) begin
            bus.cdb_valid[p]               = s.cdb_v[p];
            bus.cdb_tag[p*TAG_W +: TAG_W]  = TAG_W'(s.cdb_t[p]);
        end
        bus.ckpt_save    = s.save;
        bus.ckpt_flush   = s.flush;
        bus.ckpt_id      = CKPT_AW'(s.id);
        bus.ckpt_release = s.rel;
    endtask

    // Queue this cycle's expected outputs, then advance the model past the edge.
    task automatic predict(stim_t s);
        exp_t e;
        e.rsv = (s.rs != 0) && (own[s.rs] >= 0) && !completes(s, own[s.rs]);
        e.rst = (s.rs != 0 && own[s.rs] >= 0) ? TAG_W'(own[s.rs]) : '0;
        e.rtv = (s.rt != 0) && (own[s.rt] >= 0) && !completes(s, own[s.rt]);
        e.rtt = (s.rt != 0 && own[s.rt] >= 0) ? TAG_W'(own[s.rt]) : '0;
        e.oh  = '0;
        for (int p = 0; p < NCDB; p++)
            for (int r = 1; r < NUM_REGS; r++)
                if (s.cdb_v[p] && own[r] >= 0 && own[r] == s.cdb_t[p]) e.oh[p*NUM_REGS + r] = 1'b1;
        for (int k = 0; k < NCKPT; k++) e.ckv[k] = ckv[k];
        exp_q.push_back(e);

        for (int k = 0; k < NCKPT; k++)
            for (int r = 0; r < NUM_REGS; r++)
                if (snap[k][r] >= 0 && completes(s, snap[k][r])) snap[k][r] = -1;
        if (s.flush && ckv[s.id]) begin
            for (int r = 0; r < NUM_REGS; r++) own[r] = snap[s.id][r];
            for (int k = 0; k < NCKPT; k++) ckv[k] = 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) if (own[r] >= 0 && completes(s, own[r])) own[r] = -1;
            if (s.wen && s.waddr != 0) own[s.waddr] = completes(s, s.wtag) ? -1 : s.wtag;
            for (int k = 0; k < NCKPT; k++) if (s.rel[k]) ckv[k] = 1'b0;
            if (s.save) begin
                for (int r = 0; r < NUM_REGS; r++) snap[s.id][r] = own[r];
                ckv[s.id] = 1'b1;
            end
        end
    endtask

    task automatic step(stim_t s);
        @(posedge clk); #1;
        drive(s);
        predict(s);
    endtask

    task automatic rd(int rs, int rt);
        stim_t s;
        s = idle(); s.rs = rs; s.rt = rt;
        step(s);
    endtask

    task automatic disp(int addr, int tag, int rs, int rt);
        stim_t s;
        s = idle(); s.wen = 1; s.waddr = addr; s.wtag = tag; s.rs = rs; s.rt = rt;
        step(s);
    endtask

    // Reset is asserted mid-cycle and checked before the next edge.
    task automatic do_reset(int rs, int rt);
        stim_t s;
        @(posedge clk); #1;
        reset = 1'b0;
        s = idle(); s.rs = rs; s.rt = rt;
        drive(s);
        model_reset();
        predict(s);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic chk(string name, logic [OH_W-1:0] act, logic [OH_W-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compare whatever the driver queued for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            chk("rsvalid",    OH_W'(bus.dispatch_rsvalid),   OH_W'(m.rsv));
            chk("rstag",      OH_W'(bus.dispatch_rstag),     OH_W'(m.rst));
            chk("rtvalid",    OH_W'(bus.dispatch_rtvalid),   OH_W'(m.rtv));
            chk("rttag",      OH_W'(bus.dispatch_rttag),     OH_W'(m.rtt));
            chk("wen_onehot", bus.regfile_wen_onehot,        m.oh);
            chk("ckpt_valid", OH_W'(bus.ckpt_valid),         OH_W'(m.ckv));
        end
    end

    // Two CDB ports must never broadcast the same tag.
    always @(negedge clk) begin
        if (reset) assert (!(bus.cdb_valid[0] && bus.cdb_valid[1] &&
                             bus.cdb_tag[TAG_W-1:0] == bus.cdb_tag[2*TAG_W-1:TAG_W]));
    end

    initial begin
        stim_t s;
        int    live[$];
        int    t;
        model_reset();
        drive(idle());

        // 1: reset state
        do_reset(5, 5);
        // 2: dispatch, read back, CDB bypass + onehot, clear
        disp(5, 'h12, 5, 0);
        rd(5, 0);
        s = idle(); s.cdb_v[0] = 1; s.cdb_t[0] = 'h12; s.rs = 5; step(s);
        rd(5, 5);
        // 3: dispatch completing in the same cycle; dispatch to r0
        s = idle(); s.wen = 1; s.waddr = 7; s.wtag = 'h20; s.cdb_v[1] = 1; s.cdb_t[1] = 'h20; step(s);
        rd(7, 0);
        disp(0, 'h21, 0, 0);
        rd(0, 7);
        // 4: save, overwrite, restore
        disp(3, 'h04, 3, 0);
        s = idle(); s.save = 1; s.id = 1; s.rs = 3; step(s);
        disp(3, 'h09, 3, 4);
        disp(4, 'h0A, 3, 4);
        s = idle(); s.flush = 1; s.id = 1; s.rs = 3; s.rt = 4; step(s);
        rd(3, 4);
        // 5: checkpoint copy is cleared by the CDB
        s = idle(); s.save = 1; s.id = 2; s.rs = 3; step(s);
        s = idle(); s.cdb_v[0] = 1; s.cdb_t[0] = 'h04; s.rs = 3; step(s);
        s = idle(); s.flush = 1; s.id = 2; s.rs = 3; step(s);
        rd(3, 0);
        // 6: flush ignores same-cycle dispatch; mid-operation reset
        s = idle(); s.save = 1; s.id = 1; step(s);
        s = idle(); s.flush = 1; s.id = 1; s.wen = 1; s.waddr = 8; s.wtag = 'h11; s.save = 1; step(s);
        rd(8, 8);
        disp(9, 'h30, 9, 0);
        s = idle(); s.save = 1; s.id = 0; s.rs = 9; step(s);
        do_reset(9, 8);
        tag_ptr = 0;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            s = idle();
            s.rs = int'($urandom_range(0, NUM_REGS-1));
            s.rt = int'($urandom_range(0, NUM_REGS-1));
            if ($urandom_range(0, 9) < 6) begin
                t = free_tag();
                if (t >= 0) begin
                    s.wen = 1; s.waddr = int'($urandom_range(0, NUM_REGS-1)); s.wtag = t;
                end
            end
            live.delete();
            for (int r = 0; r < NUM_REGS; r++) begin
                if (own[r] >= 0) live.push_back(own[r]);
                for (int k = 0; k < NCKPT; k++) if (ckv[k] && snap[k][r] >= 0) live.push_back(snap[k][r]);
            end
            for (int p = 0; p < NCDB; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if (s.wen && $urandom_range(0, 9) == 0) begin
                        s.cdb_v[p] = 1; s.cdb_t[p] = s.wtag;
                    end else if (live.size() > 0) begin
                        s.cdb_v[p] = 1; s.cdb_t[p] = live[$urandom_range(0, live.size()-1)];
                    end
                end
                for (int q = 0; q < p; q++)
                    if (s.cdb_v[q] && s.cdb_v[p] && s.cdb_t[q] == s.cdb_t[p]) s.cdb_v[p] = 0;
            end
            if ($urandom_range(0, 6) == 0) begin
                s.save = 1; s.id = int'($urandom_range(0, NCKPT-1));
            end
            if ($urandom_range(0, 11) == 0) begin
                t = int'($urandom_range(0, NCKPT-1));
                if (ckv[t]) begin s.flush = 1; s.id = t; end
            end
            if ($urandom_range(0, 7) == 0) s.rel = NCKPT'($urandom);
            step(s);
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses never compared, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
